// File: rtl/sort_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_host_pkg
// Description : Shared types and constants for the byte-sorter host.
//               Holds the host FSM state encoding and the default frame
//               geometry that the sorter and its host must agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_host_pkg;

  // Frame depth and word width; the sorter is built with the same values.
  localparam int SORT_N = 8;
  localparam int SORT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_KICK    = 3'd2,
    S_WAIT    = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_SEND    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sort_host_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_host_if
// Description : Bundles the host's upstream stream, downstream stream and
//               sorter host bus.
//   master : used by sort_host (drives in_ready, out_*, srt_wr/start/addr/
//            datain, busy; receives in_valid/in_data, out_ready,
//            srt_dataout, srt_ready)
//   slave  : the surrounding environment (upstream source, downstream sink
//            and the sorter itself)
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_host_if
  import sort_host_pkg::*;
#(
  parameter int W  = SORT_W,
  parameter int AW = $clog2(SORT_N)
);

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;

  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;

  logic          srt_wr;
  logic          srt_start;
  logic [AW-1:0] srt_addr;
  logic [W-1:0]  srt_datain;
  logic [W-1:0]  srt_dataout;
  logic          srt_ready;

  logic          busy;

  modport master (
    input  in_valid, in_data, out_ready, srt_dataout, srt_ready,
    output in_ready, out_valid, out_data,
    output srt_wr, srt_start, srt_addr, srt_datain, busy
  );

  modport slave (
    output in_valid, in_data, out_ready, srt_dataout, srt_ready,
    input  in_ready, out_valid, out_data,
    input  srt_wr, srt_start, srt_addr, srt_datain, busy
  );

endinterface
`default_nettype wire

// File: rtl/sort_host.sv
`default_nettype none
// ============================================================================
// Module      : sort_host
// Description : Host-side initiator for the N-word byte sorter. Collects a
//               frame of N words from the input stream, writes them into the
//               sorter, kicks a sort, waits for completion and streams the
//               sorted words back out in address order.
// Ports       :
//   clk  - clock, all state on the rising edge
//   nrst - asynchronous active-low reset
//   bus  - sort_host_if.master: input stream (in_valid/in_data/in_ready),
//          output stream (out_valid/out_data/out_ready), sorter host bus
//          (srt_wr/srt_start/srt_addr/srt_datain/srt_dataout/srt_ready),
//          busy status
// Revision    : 1.0 - initial release
// ============================================================================
module sort_host
  import sort_host_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int W  = SORT_W,
  parameter int AW = $clog2(SORT_N)
) (
  input  logic        clk,
  input  logic        nrst,
  sort_host_if.master bus
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state_q;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] rcnt_q;
  logic          seen_low_q;

  logic          srt_wr_q;
  logic          srt_start_q;
  logic [AW-1:0] srt_addr_q;
  logic [W-1:0]  srt_datain_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;

  // Counters are N = 2**AW deep, so the plain increment wraps to zero.
  logic [AW-1:0] wcnt_d;
  logic [AW-1:0] rcnt_d;

  assign wcnt_d = wcnt_q + AW'(1);
  assign rcnt_d = rcnt_q + AW'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      seen_low_q   <= 1'b0;
      srt_wr_q     <= 1'b0;
      srt_start_q  <= 1'b0;
      srt_addr_q   <= '0;
      srt_datain_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      srt_wr_q    <= 1'b0;
      srt_start_q <= 1'b0;

      case (state_q)
        S_IDLE: state_q <= S_LOAD;

        S_LOAD: begin
          if (bus.in_valid) begin
            srt_wr_q     <= 1'b1;
            srt_addr_q   <= wcnt_q;
            srt_datain_q <= bus.in_data;
            wcnt_q       <= wcnt_d;
            if (wcnt_q == LAST) state_q <= S_KICK;
          end
        end

        // The sorter must be idle before it can accept a start.
        S_KICK: begin
          if (bus.srt_ready) begin
            srt_start_q <= 1'b1;
            seen_low_q  <= 1'b0;
            state_q     <= S_WAIT;
          end
        end

        // Completion is a fall followed by a rise of srt_ready; a ready that
        // is still high from before the start is not a completion.
        S_WAIT: begin
          if (!bus.srt_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            srt_addr_q <= '0;
            rcnt_q     <= '0;
            state_q    <= S_RD_ADDR;
          end
        end

        // srt_addr is presented for one cycle; read data follows next cycle.
        S_RD_ADDR: state_q <= S_RD_DATA;

        S_RD_DATA: begin
          out_data_q  <= bus.srt_dataout;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end

        S_SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (rcnt_q == LAST) begin
              rcnt_q  <= '0;
              state_q <= S_LOAD;
            end else begin
              rcnt_q     <= rcnt_d;
              srt_addr_q <= rcnt_d;
              state_q    <= S_RD_ADDR;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.busy       = (state_q != S_LOAD);
  assign bus.srt_wr     = srt_wr_q;
  assign bus.srt_start  = srt_start_q;
  assign bus.srt_addr   = srt_addr_q;
  assign bus.srt_datain = srt_datain_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

endmodule
`default_nettype wire

// File: doc/sort_host.md
Name: sort_host

Overview:
- Initiator for the 8-word byte sorter's host interface.
- Accepts a frame of N bytes on a valid/ready input stream and writes them into the sorter (wr/addr/datain).
- Pulses start, waits for the sorter's ready to fall and rise again, then reads the N words back in address order (0..N-1) and emits them on a valid/ready output stream.
- Sits between the system bus side and the sorter. Both blocks share clk/nrst.

Parameters:
N, 8, words per frame (power of two, must equal the sorter depth)
W, 8, data width
AW, 3, address width, equal to log2(N)

Ports:
clk  input  1  clock, all state on posedge
nrst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream word valid
in_data  input  W  upstream word
in_ready  output  1  host accepts a word (LOAD only)
out_valid  output  1  sorted word valid
out_data  output  W  sorted word
out_ready  input  1  downstream accepts
srt_wr  output  1  sorter write strobe
srt_start  output  1  sorter start pulse
srt_addr  output  AW  sorter address (write and read)
srt_datain  output  W  sorter write data
srt_dataout  input  W  sorter read data, valid the cycle after srt_addr is presented with srt_wr=0 and srt_start=0
srt_ready  input  1  sorter idle flag
busy  output  1  high in every state except LOAD

Behaviour:
- All outputs are registered, except in_ready and busy, which decode the state register only.
- Reset (nrst low, async):
  - state=IDLE; wcnt=rcnt=0.
  - srt_wr=srt_start=out_valid=0; srt_addr=0; srt_datain=0; out_data=0.
  - in_ready=0; busy=1.
- Reset mid-frame abandons the frame; no partial output follows.
- States: IDLE, LOAD, KICK, WAIT, RD_ADDR, RD_DATA, SEND (enum).
- IDLE: always goes to LOAD next cycle.
- LOAD: in_ready=1.
  - On handshake in cycle k: srt_wr=1, srt_addr=wcnt, srt_datain=in_data, all in cycle k+1; wcnt++.
  - Without a handshake, srt_wr=0 next cycle.
  - On the handshake with wcnt==N-1: wcnt wraps to 0 and the FSM moves to KICK.
- KICK:
  - If srt_ready=1: srt_start=1 for exactly the next cycle, clear the seen_low flag, go to WAIT.
  - Otherwise hold in KICK.
  - srt_start is never high in the same cycle as srt_wr; it is first high two cycles after the last input handshake.
- WAIT:
  - srt_start=0.
  - seen_low is set when srt_ready==0.
  - When srt_ready==1 and seen_low==1: srt_addr<=0, rcnt=0, go to RD_ADDR.
  - A stale ready=1 in the first WAIT cycle must not end WAIT.
- RD_ADDR: srt_addr holds rcnt for one cycle (the sorter samples it); go to RD_DATA.
- RD_DATA: out_data<=srt_dataout, out_valid<=1; go to SEND.
- SEND:
  - out_valid and out_data stay stable until out_ready.
  - On the handshake: out_valid<=0.
    - If rcnt==N-1: rcnt<=0, go to LOAD.
    - Else: rcnt++, srt_addr<=rcnt+1, go to RD_ADDR.
  - Output throughput is 1 word per 3 cycles minimum.
- Input words offered outside LOAD are not accepted (in_ready=0) and have no side effects.
- Counters are AW bits and wrap modulo N; there is no overflow path.
- srt_addr holds its last value whenever it is not being driven to a new value.

Decomposition:
- Package sort_host_pkg holds:
  - the state enum typedef (3-bit);
  - default N/W constants shared with the sorter.
- Single module, no sub-module; the FSM and two counters fit in one block.

Test Plan:
- Reset with in_valid=1 held -> in_ready=0, srt_wr=0, out_valid=0 during reset; in_ready=1 two cycles after nrst deasserts.
- Frame 5,3,7,0,1,6,2,4 with in_valid continuous -> srt_wr high 8 consecutive cycles, srt_addr 0..7, srt_datain matching; srt_start single-cycle pulse 2 cycles after the last handshake.
- Sorter model holds ready=1 for 1 cycle after start, then 0 for 20 cycles -> no read before ready returns; outputs 0,1,2,3,4,5,6,7 in order.
- out_ready toggles 1,0,0,1 per word -> out_data stable while stalled; no word lost or duplicated; in_ready=1 only after the 8th output handshake.
- srt_ready=0 when entering KICK (sorter busy) -> srt_start withheld until ready=1, then exactly one pulse.
- nrst pulsed low during WAIT -> all outputs return to reset values immediately; the next full frame 255,0,... sorts and outputs correctly.
